cpu_controller: RTL and testbench

//  Hardwired microcontroller for the TEC-8 teaching CPU. Decodes console switches, the

---
 rtl/cpu_controller_pkg.sv | 57 +++++
 rtl/cpu_controller_if.sv | 35 +++
 rtl/cpu_controller_decode.sv | 76 +++++++
 rtl/cpu_controller.sv | 144 ++++++++++++++
 tb/tb_cpu_controller.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_controller_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Purpose : Shared constants and types for the TEC-8 hardwired controller.
//           Holds the console mode codes, the opcode enumeration and the
//           packed control-strobe bundle passed between the decode blocks.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   // Console mode = {swc, swb, swa}
   localparam logic [2:0] MODE_RUN  = 3'b000;
   localparam logic [2:0] MODE_WMEM = 3'b001;
   localparam logic [2:0] MODE_RMEM = 3'b010;
   localparam logic [2:0] MODE_RREG = 3'b011;
   localparam logic [2:0] MODE_WREG = 3'b100;

   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_ADD = 4'b0001,
      OP_SUB = 4'b0010,
      OP_AND = 4'b0011,
      OP_INC = 4'b0100,
      OP_LD  = 4'b0101,
      OP_ST  = 4'b0110,
      OP_JC  = 4'b0111,
      OP_JZ  = 4'b1000,
      OP_JMP = 4'b1001,
      OP_STP = 4'b1110
   } opcode_e;

   // Every datapath strobe the controller can raise. shrt/lng are the
   // "short" and "long" beat-sequencing requests.
   typedef struct packed {
      logic       drw;
      logic       pcinc;
      logic       lpc;
      logic       lar;
      logic       pcadd;
      logic       arinc;
      logic       memw;
      logic       lir;
      logic       ldz;
      logic       ldc;
      logic       selctl;
      logic [3:0] sel;
      logic       stop;
      logic       cin;
      logic       m;
      logic [3:0] s;
      logic       abus;
      logic       sbus;
      logic       mbus;
      logic       shrt;
      logic       lng;
   } ctrl_t;

endpackage

// File: rtl/cpu_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_if
// Purpose : Bundles the console switches, instruction/beat/flag inputs and all
//           datapath strobes of the TEC-8 controller.
// Ports   : slave  - controller side (switches/beats/flags in, strobes out)
//           master - console/datapath side (drives inputs, receives strobes)
// -----------------------------------------------------------------------------
interface cpu_ctrl_if;
   logic       swc_i, swb_i, swa_i;
   logic [3:0] ir_i;
   logic       w1_i, w2_i, w3_i;
   logic       c_i, z_i;
   logic       pulse_i;

   logic drw_o, pcinc_o, lpc_o, lar_o, pcadd_o, arinc_o, memw_o, lir_o, ldz_o, ldc_o;
   logic selctl_o, sel3_o, sel2_o, sel1_o, sel0_o;
   logic stop_o, cin_o, m_o;
   logic [3:0] s_o;
   logic abus_o, sbus_o, mbus_o, short_o, long_o;
   logic dbg_led_o;

   modport slave (
      input  swc_i, swb_i, swa_i, ir_i, w1_i, w2_i, w3_i, c_i, z_i, pulse_i,
      output drw_o, pcinc_o, lpc_o, lar_o, pcadd_o, arinc_o, memw_o, lir_o, ldz_o, ldc_o,
             selctl_o, sel3_o, sel2_o, sel1_o, sel0_o, stop_o, cin_o, m_o, s_o,
             abus_o, sbus_o, mbus_o, short_o, long_o, dbg_led_o
   );

   modport master (
      output swc_i, swb_i, swa_i, ir_i, w1_i, w2_i, w3_i, c_i, z_i, pulse_i,
      input  drw_o, pcinc_o, lpc_o, lar_o, pcadd_o, arinc_o, memw_o, lir_o, ldz_o, ldc_o,
             selctl_o, sel3_o, sel2_o, sel1_o, sel0_o, stop_o, cin_o, m_o, s_o,
             abus_o, sbus_o, mbus_o, short_o, long_o, dbg_led_o
   );
endinterface

// File: rtl/cpu_controller_decode.sv
// -----------------------------------------------------------------------------
// cpu_instr_decode
// Purpose : Run-mode instruction decode. Maps the opcode to the W2/W3 strobes.
// Ports   : ir_i    - opcode (IR[7:4])
//           w2_i/w3_i - beat signals
//           c_i/z_i - carry / zero flags for conditional jumps
//           ctrl_o  - strobe bundle, all zero outside W2/W3
// -----------------------------------------------------------------------------
module cpu_instr_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] ir_i,
   input  logic       w2_i,
   input  logic       w3_i,
   input  logic       c_i,
   input  logic       z_i,
   output ctrl_t      ctrl_o
);

   opcode_e op;
   assign op = opcode_e'(ir_i);

   always_comb begin
      ctrl_o = '0;
      if (w2_i) begin
         case (op)
            OP_ADD: begin
               ctrl_o.s = 4'b1001; ctrl_o.cin = 1'b1; ctrl_o.abus = 1'b1;
               ctrl_o.drw = 1'b1; ctrl_o.ldz = 1'b1; ctrl_o.ldc = 1'b1;
            end
            OP_SUB: begin
               ctrl_o.s = 4'b0110; ctrl_o.abus = 1'b1;
               ctrl_o.drw = 1'b1; ctrl_o.ldz = 1'b1; ctrl_o.ldc = 1'b1;
            end
            OP_AND: begin
               ctrl_o.m = 1'b1; ctrl_o.s = 4'b1011; ctrl_o.abus = 1'b1;
               ctrl_o.drw = 1'b1; ctrl_o.ldz = 1'b1;
            end
            OP_INC: begin
               ctrl_o.s = 4'b0000; ctrl_o.abus = 1'b1;
               ctrl_o.drw = 1'b1; ctrl_o.ldz = 1'b1; ctrl_o.ldc = 1'b1;
            end
            // LD/ST: ALU passes the address register operand to AR, then
            // request the extra W3 beat for the memory access.
            OP_LD: begin
               ctrl_o.m = 1'b1; ctrl_o.s = 4'b1010; ctrl_o.abus = 1'b1;
               ctrl_o.lar = 1'b1; ctrl_o.lng = 1'b1;
            end
            OP_ST: begin
               ctrl_o.m = 1'b1; ctrl_o.s = 4'b1111; ctrl_o.abus = 1'b1;
               ctrl_o.lar = 1'b1; ctrl_o.lng = 1'b1;
            end
            OP_JC:  ctrl_o.pcadd = c_i;
            OP_JZ:  ctrl_o.pcadd = z_i;
            OP_JMP: begin
               ctrl_o.m = 1'b1; ctrl_o.s = 4'b1111; ctrl_o.abus = 1'b1;
               ctrl_o.lpc = 1'b1;
            end
            OP_STP: ctrl_o.stop = 1'b1;
            default: ctrl_o = '0;
         endcase
      end else if (w3_i) begin
         case (op)
            OP_LD: begin
               ctrl_o.mbus = 1'b1; ctrl_o.drw = 1'b1;
            end
            OP_ST: begin
               ctrl_o.m = 1'b1; ctrl_o.s = 4'b1010; ctrl_o.abus = 1'b1;
               ctrl_o.memw = 1'b1;
            end
            default: ctrl_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Purpose : Hardwired TEC-8 controller. Combines the console-mode decode with
//           the run-mode instruction decode to produce datapath strobes, and
//           keeps the phase bit st0 that splits each mode into two passes.
// Ports   : t3  - beat clock; state advances on its falling edge
//           clr - asynchronous active-low reset
//           bus - cpu_ctrl_if.slave: switches, IR, beats, flags in; strobes out
// -----------------------------------------------------------------------------
module cpu_controller
   import cpu_ctrl_pkg::*;
(
   input  logic       t3,
   input  logic       clr,
   cpu_ctrl_if.slave  bus
);

   logic       st0_q, st0_d;
   logic [2:0] mode_q;
   logic [2:0] mode;
   logic       w1, w2, w3;
   logic       set_st0;
   logic       mode_legal;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl_d;
   ctrl_t      ctrl_out;
   logic       unused_pulse;

   assign mode         = {bus.swc_i, bus.swb_i, bus.swa_i};
   assign w1           = bus.w1_i;
   assign w2           = bus.w2_i;
   assign w3           = bus.w3_i;
   assign mode_legal   = (mode <= MODE_WREG);
   assign unused_pulse = bus.pulse_i;

   cpu_instr_decode u_decode (
      .ir_i   (bus.ir_i),
      .w2_i   (w2),
      .w3_i   (w3),
      .c_i    (bus.c_i),
      .z_i    (bus.z_i),
      .ctrl_o (dec_ctrl)
   );

   always_comb begin
      ctrl_d  = '0;
      set_st0 = 1'b0;
      case (mode)
         MODE_RUN: begin
            if (w1) begin
               if (!st0_q) begin
                  // First pass loads the PC from the switches.
                  ctrl_d.sbus = 1'b1; ctrl_d.lpc = 1'b1;
                  ctrl_d.stop = 1'b1; ctrl_d.shrt = 1'b1;
                  set_st0     = 1'b1;
               end else begin
                  ctrl_d.lir = 1'b1; ctrl_d.pcinc = 1'b1;
               end
            end else begin
               ctrl_d = dec_ctrl;
            end
         end
         MODE_WMEM, MODE_RMEM: begin
            if (w1) begin
               ctrl_d.stop = 1'b1; ctrl_d.shrt = 1'b1; ctrl_d.selctl = 1'b1;
               if (!st0_q) begin
                  // First pass latches the start address into AR.
                  ctrl_d.sbus = 1'b1; ctrl_d.lar = 1'b1;
                  set_st0     = 1'b1;
               end else if (mode == MODE_WMEM) begin
                  ctrl_d.sbus = 1'b1; ctrl_d.memw = 1'b1; ctrl_d.arinc = 1'b1;
               end else begin
                  ctrl_d.mbus = 1'b1; ctrl_d.arinc = 1'b1;
               end
            end
         end
         MODE_RREG: begin
            if (w1 || w2) begin
               ctrl_d.selctl = 1'b1; ctrl_d.stop = 1'b1;
               ctrl_d.sel    = {w2, 1'b0, w2, 1'b1};
            end
         end
         MODE_WREG: begin
            if (w1 || w2) begin
               ctrl_d.sbus = 1'b1; ctrl_d.drw = 1'b1;
               ctrl_d.stop = 1'b1; ctrl_d.selctl = 1'b1;
               // Pass 1 targets R0/R1, pass 2 targets R2/R3.
               ctrl_d.sel  = {st0_q, w2, (~st0_q & w1) | (st0_q & w2), w1};
               set_st0     = w2 & ~st0_q;
            end
         end
         default: ctrl_d = '0;
      endcase
   end

   // Illegal modes freeze st0; otherwise a mode change restarts the sequence.
   always_comb begin
      st0_d = st0_q;
      if (mode_legal) begin
         if (mode != mode_q) st0_d = 1'b0;
         else if (set_st0)   st0_d = 1'b1;
      end
   end

   always_ff @(negedge t3 or negedge clr) begin
      if (!clr) begin
         st0_q  <= 1'b0;
         mode_q <= MODE_RUN;
      end else begin
         st0_q  <= st0_d;
         mode_q <= mode;
      end
   end

   // Reset forces every strobe low regardless of the switch/beat inputs.
   assign ctrl_out = clr ? ctrl_d : '0;

   assign bus.drw_o     = ctrl_out.drw;
   assign bus.pcinc_o   = ctrl_out.pcinc;
   assign bus.lpc_o     = ctrl_out.lpc;
   assign bus.lar_o     = ctrl_out.lar;
   assign bus.pcadd_o   = ctrl_out.pcadd;
   assign bus.arinc_o   = ctrl_out.arinc;
   assign bus.memw_o    = ctrl_out.memw;
   assign bus.lir_o     = ctrl_out.lir;
   assign bus.ldz_o     = ctrl_out.ldz;
   assign bus.ldc_o     = ctrl_out.ldc;
   assign bus.selctl_o  = ctrl_out.selctl;
   assign bus.sel3_o    = ctrl_out.sel[3];
   assign bus.sel2_o    = ctrl_out.sel[2];
   assign bus.sel1_o    = ctrl_out.sel[1];
   assign bus.sel0_o    = ctrl_out.sel[0];
   assign bus.stop_o    = ctrl_out.stop;
   assign bus.cin_o     = ctrl_out.cin;
   assign bus.m_o       = ctrl_out.m;
   assign bus.s_o       = ctrl_out.s;
   assign bus.abus_o    = ctrl_out.abus;
   assign bus.sbus_o    = ctrl_out.sbus;
   assign bus.mbus_o    = ctrl_out.mbus;
   assign bus.short_o   = ctrl_out.shrt;
   assign bus.long_o    = ctrl_out.lng;
   assign bus.dbg_led_o = st0_q;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
// Purpose : Directed self-checking bench for cpu_controller. Each step drives
//           one beat after a falling t3, queues the expected strobe vector and
//           compares it mid-beat; st0 advances on the following falling t3.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

   logic t3;
   logic clr;

   cpu_ctrl_if bus ();

   cpu_controller dut (
      .t3  (t3),
      .clr (clr),
      .bus (bus)
   );

   initial t3 = 1'b0;
   always #5 t3 = ~t3;

   // Observed vector layout (MSB..LSB):
   // drw pcinc lpc lar pcadd arinc memw lir ldz ldc selctl sel[3:0] stop cin m s[3:0]
   // abus sbus mbus short long dbg_led
   localparam logic [27:0] DRW    = 28'd1 << 27;
   localparam logic [27:0] PCINC  = 28'd1 << 26;
   localparam logic [27:0] LPC    = 28'd1 << 25;
   localparam logic [27:0] LAR    = 28'd1 << 24;
   localparam logic [27:0] PCADD  = 28'd1 << 23;
   localparam logic [27:0] ARINC  = 28'd1 << 22;
   localparam logic [27:0] MEMW   = 28'd1 << 21;
   localparam logic [27:0] LIR    = 28'd1 << 20;
   localparam logic [27:0] LDZ    = 28'd1 << 19;
   localparam logic [27:0] LDC    = 28'd1 << 18;
   localparam logic [27:0] SELCTL = 28'd1 << 17;
   localparam logic [27:0] STOP   = 28'd1 << 12;
   localparam logic [27:0] CIN    = 28'd1 << 11;
   localparam logic [27:0] M      = 28'd1 << 10;
   localparam logic [27:0] ABUS   = 28'd1 << 5;
   localparam logic [27:0] SBUS   = 28'd1 << 4;
   localparam logic [27:0] MBUS   = 28'd1 << 3;
   localparam logic [27:0] SHORT  = 28'd1 << 2;
   localparam logic [27:0] LONG   = 28'd1 << 1;
   localparam logic [27:0] DBG    = 28'd1;

   function automatic logic [27:0] SEL(input logic [3:0] v);
      return 28'(v) << 13;
   endfunction

   function automatic logic [27:0] S(input logic [3:0] v);
      return 28'(v) << 6;
   endfunction

   logic [27:0] sb_q[$];
   int          tests_run  = 0;
   int          tests_fail = 0;

   function automatic logic [27:0] observe();
      return {bus.drw_o, bus.pcinc_o, bus.lpc_o, bus.lar_o, bus.pcadd_o, bus.arinc_o,
              bus.memw_o, bus.lir_o, bus.ldz_o, bus.ldc_o, bus.selctl_o,
              bus.sel3_o, bus.sel2_o, bus.sel1_o, bus.sel0_o,
              bus.stop_o, bus.cin_o, bus.m_o, bus.s_o,
              bus.abus_o, bus.sbus_o, bus.mbus_o, bus.short_o, bus.long_o, bus.dbg_led_o};
   endfunction

   // beats = {w1,w2,w3}
   task automatic step(input logic rst_n, input logic [2:0] mode, input logic [3:0] ir,
                       input logic [2:0] beats, input logic c, input logic z,
                       input string tag, input logic [27:0] exp);
      logic [27:0] obs;
      logic [27:0] want;
      @(negedge t3);
      #1;
      clr = rst_n;
      {bus.swc_i, bus.swb_i, bus.swa_i} = mode;
      bus.ir_i = ir;
      {bus.w1_i, bus.w2_i, bus.w3_i} = beats;
      bus.c_i = c;
      bus.z_i = z;
      bus.pulse_i = $urandom_range(0, 1) != 0;
      sb_q.push_back(exp);
      @(posedge t3);
      #1;
      obs = observe();
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_fail++;
         $error("FAIL %s: observed %h required entry missing from scoreboard", tag, obs);
      end else begin
         want = sb_q.pop_front();
         assert (obs === want) else begin
            tests_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
         end
      end
   endtask

   initial begin
      clr = 1'b0;
      bus.swc_i = 1'b0; bus.swb_i = 1'b0; bus.swa_i = 1'b0;
      bus.ir_i = 4'b0; bus.w1_i = 1'b0; bus.w2_i = 1'b0; bus.w3_i = 1'b0;
      bus.c_i = 1'b0; bus.z_i = 1'b0; bus.pulse_i = 1'b0;

      // Reset holds everything low whatever the stimulus
      step(1'b0, 3'b100, 4'b0101, 3'b100, 1'b1, 1'b1, "rst_wreg", 28'd0);
      step(1'b0, 3'b000, 4'b0001, 3'b010, 1'b1, 1'b0, "rst_run",  28'd0);
      step(1'b1, 3'b000, 4'b0010, 3'b000, 1'b0, 1'b0, "rel_idle", 28'd0);
      step(1'b1, 3'b000, 4'b0010, 3'b000, 1'b0, 1'b0, "st0_low",  28'd0);

      // Run mode: PC load, fetch, execute
      step(1'b1, 3'b000, 4'b0010, 3'b100, 1'b0, 1'b0, "run_ldpc", SBUS | LPC | STOP | SHORT);
      step(1'b1, 3'b000, 4'b0010, 3'b000, 1'b0, 1'b0, "run_nobeat", DBG);
      step(1'b1, 3'b000, 4'b0010, 3'b100, 1'b0, 1'b0, "run_fetch", LIR | PCINC | DBG);
      step(1'b1, 3'b000, 4'b0010, 3'b010, 1'b0, 1'b0, "sub_w2",
           S(4'b0110) | ABUS | DRW | LDZ | LDC | DBG);
      step(1'b1, 3'b000, 4'b0101, 3'b010, 1'b0, 1'b0, "ld_w2",
           M | S(4'b1010) | ABUS | LAR | LONG | DBG);
      step(1'b1, 3'b000, 4'b0101, 3'b001, 1'b0, 1'b0, "ld_w3", MBUS | DRW | DBG);
      step(1'b1, 3'b000, 4'b0111, 3'b010, 1'b0, 1'b1, "jc_c0", DBG);
      step(1'b1, 3'b000, 4'b0111, 3'b010, 1'b1, 1'b0, "jc_c1", PCADD | DBG);
      step(1'b1, 3'b000, 4'b1000, 3'b010, 1'b0, 1'b1, "jz_z1", PCADD | DBG);
      step(1'b1, 3'b000, 4'b0001, 3'b010, 1'b0, 1'b0, "add_w2",
           S(4'b1001) | CIN | ABUS | DRW | LDZ | LDC | DBG);
      step(1'b1, 3'b000, 4'b0011, 3'b010, 1'b0, 1'b0, "and_w2",
           M | S(4'b1011) | ABUS | DRW | LDZ | DBG);
      step(1'b1, 3'b000, 4'b0110, 3'b001, 1'b0, 1'b0, "st_w3",
           M | S(4'b1010) | ABUS | MEMW | DBG);
      step(1'b1, 3'b000, 4'b1001, 3'b010, 1'b0, 1'b0, "jmp_w2",
           M | S(4'b1111) | ABUS | LPC | DBG);
      step(1'b1, 3'b000, 4'b1110, 3'b010, 1'b0, 1'b0, "stp_w2", STOP | DBG);
      step(1'b1, 3'b000, 4'b1111, 3'b010, 1'b1, 1'b1, "nop_w2", DBG);

      // Register write: switching mode restarts the pass
      step(1'b1, 3'b100, 4'b0000, 3'b000, 1'b0, 1'b0, "wreg_enter", DBG);
      step(1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, "wreg_p1w1",
           SBUS | DRW | STOP | SELCTL | SEL(4'b0011));
      step(1'b1, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, "wreg_p1w2",
           SBUS | DRW | STOP | SELCTL | SEL(4'b0100));
      step(1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, "wreg_p2w1",
           SBUS | DRW | STOP | SELCTL | SEL(4'b1001) | DBG);
      step(1'b1, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, "wreg_p2w2",
           SBUS | DRW | STOP | SELCTL | SEL(4'b1110) | DBG);

      // Register read
      step(1'b1, 3'b011, 4'b0000, 3'b000, 1'b0, 1'b0, "rreg_enter", DBG);
      step(1'b1, 3'b011, 4'b0000, 3'b100, 1'b0, 1'b0, "rreg_w1", SELCTL | STOP | SEL(4'b0001));
      step(1'b1, 3'b011, 4'b0000, 3'b010, 1'b0, 1'b0, "rreg_w2", SELCTL | STOP | SEL(4'b1011));

      // Memory write then switch to memory read
      step(1'b1, 3'b001, 4'b0000, 3'b000, 1'b0, 1'b0, "wmem_enter", 28'd0);
      step(1'b1, 3'b001, 4'b0000, 3'b100, 1'b0, 1'b0, "wmem_addr",
           SBUS | LAR | STOP | SHORT | SELCTL);
      step(1'b1, 3'b001, 4'b0000, 3'b100, 1'b0, 1'b0, "wmem_data",
           SBUS | MEMW | ARINC | STOP | SHORT | SELCTL | DBG);
      step(1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, "rmem_stale",
           MBUS | ARINC | STOP | SHORT | SELCTL | DBG);
      step(1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, "rmem_restart",
           SBUS | LAR | STOP | SHORT | SELCTL);
      step(1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, "rmem_read",
           MBUS | ARINC | STOP | SHORT | SELCTL | DBG);

      // Illegal modes: no strobes, st0 held
      step(1'b1, 3'b101, 4'b0001, 3'b100, 1'b0, 1'b0, "ill_101", DBG);
      step(1'b1, 3'b111, 4'b0001, 3'b010, 1'b0, 1'b0, "ill_111", DBG);

      // Asynchronous reset mid-run
      step(1'b0, 3'b000, 4'b0001, 3'b010, 1'b1, 1'b1, "rst_async", 28'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
